// File: rtl/mux_4_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_4_reg_pkg
//   Shared constants for the registered 4:1 word multiplexer.
//   - MUX4_SEL_IN0..MUX4_SEL_IN3 : select encodings for in0..in3
//   - MUX4_WIDTH_DEFAULT         : default data width
// -----------------------------------------------------------------------------
package mux_4_reg_pkg;

    localparam logic [1:0] MUX4_SEL_IN0 = 2'd0;
    localparam logic [1:0] MUX4_SEL_IN1 = 2'd1;
    localparam logic [1:0] MUX4_SEL_IN2 = 2'd2;
    localparam logic [1:0] MUX4_SEL_IN3 = 2'd3;

    localparam int MUX4_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/mux_4_reg_mux_2_w.sv
// -----------------------------------------------------------------------------
// mux_2_w
//   Combinational WIDTH-bit 2:1 multiplexer, the building block of the
//   mux_4_reg selection tree.
//   Ports:
//     out    : selected word (in0 when select=0, in1 when select=1)
//     select : 1-bit selector
//     in0    : data input 0
//     in1    : data input 1
// -----------------------------------------------------------------------------
module mux_2_w
    import mux_4_reg_pkg::*;
#(
    parameter int WIDTH = MUX4_WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] out,
    input  logic             select,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1
);

    assign out = select ? in1 : in0;

endmodule

// File: rtl/mux_4_reg.sv
// -----------------------------------------------------------------------------
// mux_4_reg
//   Registered 4:1 word multiplexer. A two-level tree of 2:1 muxes selects one
//   of in0..in3, and the result is captured into the output register when
//   in_valid is high. Latency is one clock; out only changes at clock edges.
//   Ports:
//     clock     : system clock, rising edge active
//     reset     : synchronous active-high reset (clears out and out_valid)
//     select    : 0->in0, 1->in1, 2->in2, 3->in3
//     in_valid  : load enable for the output register
//     in0..in3  : WIDTH-bit data inputs
//     out       : registered selected word
//     out_valid : set on the first load after reset, held until next reset
// -----------------------------------------------------------------------------
module mux_4_reg
    import mux_4_reg_pkg::*;
#(
    parameter int WIDTH = MUX4_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       select,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] lo_pair;
    logic [WIDTH-1:0] hi_pair;
    logic [WIDTH-1:0] tree_out;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    // Stage 0: combinational selection tree (select[0] first, then select[1])
    mux_2_w #(.WIDTH(WIDTH)) u_mux_lo (
        .out    (lo_pair),
        .select (select[0]),
        .in0    (in0),
        .in1    (in1)
    );

    mux_2_w #(.WIDTH(WIDTH)) u_mux_hi (
        .out    (hi_pair),
        .select (select[0]),
        .in0    (in2),
        .in1    (in3)
    );

    mux_2_w #(.WIDTH(WIDTH)) u_mux_root (
        .out    (tree_out),
        .select (select[1]),
        .in0    (lo_pair),
        .in1    (hi_pair)
    );

    // Stage 1: output register; reset wins over a simultaneous load and
    // out_valid is sticky once set.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (in_valid) begin
            data_p1 <= tree_out;
            vld_p1  <= 1'b1;
        end
    end

    assign out       = data_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_4_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_4_reg
//   Directed self-checking bench for mux_4_reg with a 32-bit and an 8-bit
//   instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_mux_4_reg;

    logic        clock;
    logic        reset;
    logic [1:0]  select;
    logic        in_valid;
    logic [31:0] in0, in1, in2, in3;
    logic [31:0] out;
    logic        out_valid;

    logic [1:0]  select8;
    logic        in_valid8;
    logic [7:0]  in0_8, in1_8, in2_8, in3_8;
    logic [7:0]  out8;
    logic        out_valid8;

    int n_checks = 0;
    int n_fail   = 0;

    mux_4_reg #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .select    (select),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out       (out),
        .out_valid (out_valid)
    );

    mux_4_reg #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .select    (select8),
        .in_valid  (in_valid8),
        .in0       (in0_8),
        .in1       (in1_8),
        .in2       (in2_8),
        .in3       (in3_8),
        .out       (out8),
        .out_valid (out_valid8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in0 = 32'd5; in1 = 32'd6; in2 = 32'd7; in3 = 32'd8;
        select = 2'd2; in_valid = 1'b1; reset = 1'b1;
        step();
        step();
        n_checks++;
        if (out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected %h", out, 32'd0);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out8 !== 8'd0 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got out=%h valid=%b expected out=00 valid=0", out8, out_valid8);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (out !== 32'd7 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got out=%h valid=%b expected out=%h valid=1", out, out_valid, 32'd7);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        in0 = 32'd0; in1 = 32'd1; in2 = 32'd2; in3 = 32'd3;
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            exp = 32'(s);
            step();
            n_checks++;
            if (out !== exp || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_sel%0d: got out=%h valid=%b expected out=%h valid=1", s, out, out_valid, exp);
            end
        end
    endtask

    task automatic test_hold();
        in3 = 32'hDEADBEEF; select = 2'd3; in_valid = 1'b1;
        step();
        n_checks++;
        if (out !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL hold_load: got %h expected DEADBEEF", out);
        end
        in_valid = 1'b0; select = 2'd0; in3 = 32'd0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (out !== 32'hDEADBEEF || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got out=%h valid=%b expected out=DEADBEEF valid=1", c, out, out_valid);
            end
        end
    endtask

    task automatic test_bit_independence();
        logic [31:0] pat [4];
        pat[0] = 32'h0000FFFF; pat[1] = 32'hFFFF0000;
        pat[2] = 32'hAAAAAAAA; pat[3] = 32'h55555555;
        in0 = pat[0]; in1 = pat[1]; in2 = pat[2]; in3 = pat[3];
        in_valid = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            select = 2'(s);
            step();
            n_checks++;
            if (out !== pat[s]) begin
                n_fail++;
                $display("FAIL bits_sel%0d: got %h expected %h", s, out, pat[s]);
            end
        end
    endtask

    task automatic test_reset_priority();
        in1 = 32'd9; select = 2'd1; in_valid = 1'b1; reset = 1'b1;
        step();
        n_checks++;
        if (out !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstprio_edge: got out=%h valid=%b expected out=0 valid=0", out, out_valid);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (out !== 32'd9 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstprio_after: got out=%h valid=%b expected out=%h valid=1", out, out_valid, 32'd9);
        end
    endtask

    task automatic test_width8();
        n_checks++;
        if (out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_idle_valid: got %b expected 0", out_valid8);
        end
        in0_8 = 8'h11; in1_8 = 8'h22; in2_8 = 8'h33; in3_8 = 8'h44;
        select8 = 2'd2; in_valid8 = 1'b1;
        step();
        n_checks++;
        if (out8 !== 8'h33 || out_valid8 !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_sel2: got out=%h valid=%b expected out=33 valid=1", out8, out_valid8);
        end
        select8 = 2'd3;
        step();
        n_checks++;
        if (out8 !== 8'h44) begin
            n_fail++;
            $display("FAIL w8_sel3: got %h expected 44", out8);
        end
        in_valid8 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; select = 2'd0; in_valid = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        select8 = 2'd0; in_valid8 = 1'b0;
        in0_8 = '0; in1_8 = '0; in2_8 = '0; in3_8 = '0;
        #2;
        test_reset();
        test_sweep();
        test_hold();
        test_bit_independence();
        test_reset_priority();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
